ex_muldiv_unit: RTL and testbench

//  Iterative unsigned multiply/divide unit on the execute side of the ID/IE boundary.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/ex_muldiv_unit.sv | 157 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// The divider datapath is included only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

   localparam int MULDIV_WIDTH = 32;
   localparam int CNT_W        = $clog2(MULDIV_WIDTH + 1);

   typedef enum logic [1:0] {
      OP_MUL   = 2'b00,
      OP_MULHU = 2'b01,
      OP_DIVU  = 2'b10,
      OP_REMU  = 2'b11
   } muldiv_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DONE = 2'b10
   } muldiv_state_t;

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit, one iteration per cycle.
// Fixed latency: WIDTH cycles in BUSY, then a one-cycle DONE with doneM high.
// Optional feature: define MULDIV_DIV_EN to build the restoring divider;
// without it DIVU/REMU keep the same timing but return zero.
//
// Handshake: an op is accepted on a rising edge where readyE && startE && !flushE.
// readyE is high in IDLE and DONE, so a new op may be issued in the DONE cycle.
// doneM is a one-cycle valid for resultM/rdM; there is no back-pressure on it.
module ex_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic                startE,
   input  logic [1:0]          opE,
   input  logic [WIDTH-1:0]    aE,
   input  logic [WIDTH-1:0]    bE,
   input  logic [4:0]          rdE,
   input  logic                flushE,
   output logic                readyE,
   output logic                busyE,
   output logic                doneM,
   output logic [WIDTH-1:0]    resultM,
   output logic [4:0]          rdM,
   output muldiv_state_t       state_dbg
);

   localparam int CNT_BITS = $clog2(WIDTH + 1);

   muldiv_state_t         state_q, state_d;
   logic                  accept;
   logic [CNT_BITS-1:0]   cnt_q;
   muldiv_op_t            op_q;
   logic [WIDTH-1:0]      b_q;
   logic [4:0]            rd_q;
   // hi_q: high accumulator (MUL) or partial remainder (DIV); lo_q: multiplier or quotient.
   logic [WIDTH:0]        hi_q, hi_nxt;
   logic [WIDTH-1:0]      lo_q, lo_nxt;
   logic [WIDTH-1:0]      addend;
   logic [WIDTH:0]        sum;
   logic [WIDTH-1:0]      result_nxt;
   logic                  last_iter;

   assign last_iter = (cnt_q == CNT_BITS'(1));
   assign readyE    = (state_q != S_BUSY);
   assign busyE     = (state_q == S_BUSY);
   assign doneM     = (state_q == S_DONE);
   assign state_dbg = state_q;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next state and accept decision; flush always wins over start
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (startE && !flushE) begin
               accept  = 1'b1;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (flushE)         state_d = S_IDLE;
            else if (last_iter) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef MULDIV_DIV_EN
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;
`endif

   // One shift-add or restore-divide step on the shared registers
   always_comb begin
      hi_nxt = hi_q;
      lo_nxt = lo_q;
      addend = lo_q[0] ? b_q : '0;
      sum    = hi_q + {1'b0, addend};
`ifdef MULDIV_DIV_EN
      shifted = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
      trial   = shifted - {1'b0, b_q};
`endif
      case (op_q)
         OP_MUL, OP_MULHU: begin
            hi_nxt = {1'b0, sum[WIDTH:1]};
            lo_nxt = {sum[0], lo_q[WIDTH-1:1]};
         end
         default: begin
`ifdef MULDIV_DIV_EN
            // A set sign bit means the trial went negative: keep the shifted remainder
            if (!trial[WIDTH]) begin
               hi_nxt = trial;
               lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_nxt = shifted;
               lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
            end
`endif
         end
      endcase
   end

   // Result selection from the values produced by the final iteration
   always_comb begin
      result_nxt = '0;
      case (op_q)
         OP_MUL:   result_nxt = lo_nxt;
         OP_MULHU: result_nxt = hi_nxt[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
         OP_DIVU:  result_nxt = lo_nxt;
         OP_REMU:  result_nxt = hi_nxt[WIDTH-1:0];
`endif
         default:  result_nxt = '0;
      endcase
   end

   // Operand capture on accept, iteration in BUSY, result write on the last step
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q   <= '0;
         op_q    <= OP_MUL;
         b_q     <= '0;
         rd_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         resultM <= '0;
         rdM     <= '0;
      end else if (accept) begin
         cnt_q <= CNT_BITS'(WIDTH);
         op_q  <= muldiv_op_t'(opE);
         b_q   <= bE;
         rd_q  <= rdE;
         hi_q  <= '0;
         lo_q  <= aE;
      end else if (state_q == S_BUSY && !flushE) begin
         cnt_q <= cnt_q - CNT_BITS'(1);
         hi_q  <= hi_nxt;
         lo_q  <= lo_nxt;
         if (last_iter) begin
            resultM <= result_nxt;
            rdM     <= rd_q;
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit (default build or with MULDIV_DIV_EN).
module tb_ex_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           reset;
   logic           startE;
   logic           flushE;
   logic [1:0]     opE;
   logic [W-1:0]   aE;
   logic [W-1:0]   bE;
   logic [4:0]     rdE;
   logic           readyE;
   logic           busyE;
   logic           doneM;
   logic [W-1:0]   resultM;
   logic [4:0]     rdM;
   muldiv_state_t  state_dbg;

   int             checks = 0;
   int             errors = 0;
   logic [W-1:0]   exp_q[$];
   logic [4:0]     exp_rd_q[$];
   logic [W-1:0]   last_result;

   // Clock
   always #5 clk = ~clk;

   ex_muldiv_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .startE    (startE),
      .opE       (opE),
      .aE        (aE),
      .bE        (bE),
      .rdE       (rdE),
      .flushE    (flushE),
      .readyE    (readyE),
      .busyE     (busyE),
      .doneM     (doneM),
      .resultM   (resultM),
      .rdM       (rdM),
      .state_dbg (state_dbg)
   );

   // Reference model: plain arithmetic on the operation definitions
   function automatic logic [W-1:0] ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      case (op)
         2'd0: return p[W-1:0];
         2'd1: return p[2*W-1:W];
`ifdef MULDIV_DIV_EN
         2'd2: return (b == 0) ? {W{1'b1}} : a / b;
         default: return (b == 0) ? a : a % b;
`else
         default: return '0;
`endif
      endcase
   endfunction

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Driver: present an op at the current negedge; it is accepted at the next posedge
   task automatic drive(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] rd, input logic [W-1:0] exp);
      check("ready_at_issue", {31'd0, readyE}, 1);
      startE = 1'b1; opE = op; aE = a; bE = b; rdE = rd;
      exp_q.push_back(exp);
      exp_rd_q.push_back(rd);
      @(negedge clk);
      startE = 1'b0;
      check("busy_after_accept", {31'd0, busyE}, 1);
   endtask

   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] rd, input logic [W-1:0] exp);
      @(negedge clk);
      drive(op, a, b, rd, exp);
   endtask

   task automatic issue_rand(input bit now);
      logic [1:0]   op;
      logic [W-1:0] a, b;
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
         0: a = '0;
         1: a = '1;
         default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
         0: b = '0;
         1: b = '1;
         2: b = W'($urandom_range(1, 15));
         default: b = $urandom;
      endcase
      if (!now) @(negedge clk);
      drive(op, a, b, 5'($urandom_range(0, 31)), ref_model(op, a, b));
   endtask

   // Scoreboard: wait (bounded) for doneM, then compare against the expected queue
   task automatic expect_done(input string tag, input int exp_lat);
      int           lat;
      logic [W-1:0] e;
      logic [4:0]   erd;
      lat = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (doneM === 1'b1) begin
            lat = i;
            break;
         end
      end
      e   = exp_q.pop_front();
      erd = exp_rd_q.pop_front();
      check({tag, "_latency"}, W'(lat), W'(exp_lat));
      if (lat != 0) begin
         check({tag, "_result"}, resultM, e);
         check({tag, "_rd"}, {27'd0, rdM}, {27'd0, erd});
         last_result = e;
      end
   endtask

   task automatic expect_idle_after_done(input string tag);
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'd0, doneM}, 0);
      check({tag, "_result_hold"}, resultM, last_result);
      check({tag, "_ready"}, {31'd0, readyE}, 1);
   endtask

   task automatic expect_no_done(input string tag, input int cycles);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (doneM !== 1'b0) seen = 1'b1;
      end
      check({tag, "_no_done"}, {31'd0, seen}, 0);
   endtask

   initial begin
      // Reset
      reset = 1'b0; startE = 1'b0; flushE = 1'b0; opE = '0; aE = '0; bE = '0; rdE = '0;
      last_result = '0;
      #12;
      check("rst_ready", {31'd0, readyE}, 1);
      check("rst_busy", {31'd0, busyE}, 0);
      check("rst_done", {31'd0, doneM}, 0);
      check("rst_result", resultM, 0);
      check("rst_rd", {27'd0, rdM}, 0);
      check("rst_state", W'(state_dbg), W'(S_IDLE));
      @(negedge clk);
      reset = 1'b1;

      // MUL 7*6
      issue(2'b00, 32'd7, 32'd6, 5'd5, 32'h0000_002A);
      expect_done("mul_7x6", 32);
      expect_idle_after_done("mul_7x6");

      // MULHU / MUL of all ones
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'hFFFF_FFFE);
      expect_done("mulhu_ones", 32);
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'h0000_0001);
      expect_done("mul_ones", 32);
      expect_idle_after_done("mul_ones");

`ifdef MULDIV_DIV_EN
      issue(2'b10, 32'd100, 32'd7, 5'd11, 32'h0000_000E);
      expect_done("divu_100_7", 32);
      issue(2'b11, 32'd100, 32'd7, 5'd12, 32'h0000_0002);
      expect_done("remu_100_7", 32);
      issue(2'b10, 32'd123, 32'd0, 5'd13, 32'hFFFF_FFFF);
      expect_done("divu_by0", 32);
      issue(2'b11, 32'd123, 32'd0, 5'd14, 32'h0000_007B);
      expect_done("remu_by0", 32);
`else
      issue(2'b10, 32'd123, 32'd0, 5'd13, 32'h0000_0000);
      expect_done("divu_by0", 32);
      issue(2'b11, 32'd123, 32'd0, 5'd14, 32'h0000_0000);
      expect_done("remu_by0", 32);
`endif
      expect_idle_after_done("div");

      // Flush at BUSY cycle 10
      issue(2'b00, 32'd3, 32'd5, 5'd20, 32'd15);
      repeat (9) @(negedge clk);
      flushE = 1'b1;
      @(negedge clk);
      flushE = 1'b0;
      void'(exp_q.pop_back());
      void'(exp_rd_q.pop_back());
      check("flush_ready", {31'd0, readyE}, 1);
      check("flush_busy", {31'd0, busyE}, 0);
      expect_no_done("flush", 40);
      check("flush_result_hold", resultM, last_result);

      // startE together with flushE in IDLE is not accepted
      @(negedge clk);
      startE = 1'b1; flushE = 1'b1; opE = 2'b00; aE = 32'd2; bE = 32'd2; rdE = 5'd21;
      @(negedge clk);
      startE = 1'b0; flushE = 1'b0;
      check("start_flush_busy", {31'd0, busyE}, 0);
      check("start_flush_ready", {31'd0, readyE}, 1);
      expect_no_done("start_flush", 40);

      // Back-to-back: second op issued in the DONE cycle of the first
      issue(2'b00, 32'd1000, 32'd1000, 5'd22, 32'd1000000);
      expect_done("b2b_first", 32);
      drive(2'b01, 32'h8000_0000, 32'h0000_0004, 5'd23, 32'h0000_0002);
      expect_done("b2b_second", 32);
      expect_idle_after_done("b2b");

      // Async reset at BUSY cycle 5
      issue(2'b00, 32'd11, 32'd13, 5'd24, 32'd143);
      repeat (4) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      void'(exp_q.pop_back());
      void'(exp_rd_q.pop_back());
      check("arst_ready", {31'd0, readyE}, 1);
      check("arst_busy", {31'd0, busyE}, 0);
      check("arst_done", {31'd0, doneM}, 0);
      check("arst_result", resultM, 0);
      check("arst_rd", {27'd0, rdM}, 0);
      @(negedge clk);
      reset = 1'b1;
      last_result = '0;
      expect_no_done("arst", 40);

      // Randomized ops, some issued back-to-back from the DONE cycle
      issue_rand(1'b0);
      for (int i = 0; i < 16; i++) begin
         expect_done("rand", 32);
         if (i < 15) issue_rand(bit'($urandom_range(0, 1)));
      end
      expect_idle_after_done("rand");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
